// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, colour codes and width defaults for the memory game
package game_pkg;
    localparam int P_ROUND_DEF = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;
    typedef logic [1:0] colour_t;
    localparam colour_t RED    = 2'd0;
    localparam colour_t GREEN  = 2'd1;
    localparam colour_t BLUE   = 2'd2;
    localparam colour_t YELLOW = 2'd3;
endpackage

// File: rtl/round_checker_if.sv
// round_checker_if: game-progress bus between the round checker and its neighbours
//   master: drives start/tick/show_done/btn_valid/btn_code/seq_data, observes the rest
//   slave : the round checker; drives seq_addr/show_req/round/playing/end_game/win
interface round_checker_if #(parameter int P_ROUND = game_pkg::P_ROUND_DEF);
    import game_pkg::*;
    logic               start;
    logic               tick;
    logic               show_done;
    logic               btn_valid;
    colour_t            btn_code;
    colour_t            seq_data;
    logic [P_ROUND-1:0] seq_addr;
    logic               show_req;
    logic [P_ROUND-1:0] round;
    logic               playing;
    logic               end_game;
    logic               win;
    modport master (
        output start, tick, show_done, btn_valid, btn_code, seq_data,
        input  seq_addr, show_req, round, playing, end_game, win
    );
    modport slave (
        input  start, tick, show_done, btn_valid, btn_code, seq_data,
        output seq_addr, show_req, round, playing, end_game, win
    );
endinterface

// File: rtl/timeout_counter.sv
// timeout_counter: counts tick strobes since the last clear and flags the P_TIMEOUT-th one
//   clock/reset : system clock, synchronous active-low reset
//   clear       : holds the count at zero (also suppresses expired)
//   tick        : timebase strobe to count
//   expired     : high in the cycle of the tick that completes the timeout
module timeout_counter #(
    parameter int P_TIMEOUT = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int W = $clog2(P_TIMEOUT + 1);
    logic [W-1:0] timer;
    // flag on the counting tick itself so the parent leaves WAIT on that same edge
    assign expired = tick && !clear && timer == W'(P_TIMEOUT - 1);
    always_ff @(posedge clock)
        if (!reset || clear) timer <= '0;
        else if (tick) timer <= timer + 1'b1;
endmodule

// File: rtl/round_checker.sv
// round_checker: game-progress FSM of the sequence memory game
//   clock/reset : system clock, synchronous active-low reset
//   bus (slave) : start/tick/show_done/press inputs, combinational sequence read
//                 (seq_addr -> seq_data), and show_req/round/playing/end_game/win status
module round_checker
    import game_pkg::*;
#(
    parameter int P_ROUND     = P_ROUND_DEF,
    parameter int P_MAX_ROUND = 15,
    parameter int P_TIMEOUT   = 5
) (
    input logic            clock,
    input logic            reset,
    round_checker_if.slave bus
);
    state_t             state, state_n;
    logic [P_ROUND-1:0] round, round_n, round_inc, pos, pos_n;
    logic               win, win_n, hit, clear, expired;
    assign hit       = bus.btn_code == bus.seq_data;
    assign round_inc = round + 1'b1;
    // any press restarts the inactivity window; outside WAIT the timer is parked at zero
    assign clear     = state != WAIT || bus.btn_valid;
    timeout_counter #(.P_TIMEOUT(P_TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .tick   (bus.tick),
        .expired(expired)
    );
    always_comb begin
        state_n = state;
        round_n = round;
        pos_n   = pos;
        win_n   = win;
        case (state)
            IDLE, DONE: if (bus.start) begin
                state_n = SHOW;
                round_n = '0;
                pos_n   = '0;
                win_n   = 1'b0;
            end
            SHOW: if (bus.show_done) begin
                state_n = WAIT;
                pos_n   = '0;
            end
            WAIT: if (bus.btn_valid) begin
                if (!hit) state_n = DONE;
                else if (pos != round) pos_n = pos + 1'b1;
                else begin
                    round_n = round_inc;
                    win_n   = round_inc == P_ROUND'(P_MAX_ROUND);
                    state_n = win_n ? DONE : SHOW;
                end
            end else if (expired) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        if (!reset) begin
            state <= IDLE;
            round <= '0;
            pos   <= '0;
            win   <= 1'b0;
        end else begin
            state <= state_n;
            round <= round_n;
            pos   <= pos_n;
            win   <= win_n;
        end
    assign bus.show_req = state == SHOW;
    assign bus.playing  = state == SHOW || state == WAIT;
    assign bus.end_game = state == DONE;
    assign bus.win      = win;
    assign bus.round    = round;
    // the compared position stays visible in DONE so scoring can see where play stopped
    assign bus.seq_addr = (state == WAIT || state == DONE) ? pos : '0;
endmodule

// File: tb/tb_round_checker.sv
// tb_round_checker: randomized directed bench for round_checker against a rule-level model
module tb_round_checker;
    import game_pkg::*;
    localparam int MAXR = 4;
    localparam int TOUT = 3;
    typedef enum {M_IDLE, M_SHOW, M_WAIT, M_DONE} mstate_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    round_checker_if #(.P_ROUND(4)) bus ();
    round_checker #(.P_ROUND(4), .P_MAX_ROUND(MAXR), .P_TIMEOUT(TOUT)) dut (
        .clock(clk),
        .reset(reset),
        .bus  (bus)
    );
    colour_t mem [16];
    assign bus.seq_data = mem[bus.seq_addr];
    mstate_t ms = M_IDLE;
    int mr = 0, mp = 0, mt = 0;
    bit mw = 1'b0;
    int checks = 0, errors = 0;
    string phase = "init";
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s/%s: got %0d, expected %0d", phase, tag, got, exp);
        end
    endtask
    task automatic check_outputs();
        chk("show_req", 8'(bus.show_req), 8'(ms == M_SHOW));
        chk("playing", 8'(bus.playing), 8'(ms == M_SHOW || ms == M_WAIT));
        chk("end_game", 8'(bus.end_game), 8'(ms == M_DONE));
        chk("win", 8'(bus.win), 8'(ms == M_DONE && mw));
        chk("round", 8'(bus.round), 8'(mr));
        if (ms != M_SHOW) chk("seq_addr", 8'(bus.seq_addr), 8'(mp));
    endtask
    // one clock: drive inputs, advance the model by the game rules, compare after the edge
    task automatic step(input bit s, input bit t, input bit sd, input bit bv, input colour_t bc);
        bus.start = s;
        bus.tick = t;
        bus.show_done = sd;
        bus.btn_valid = bv;
        bus.btn_code = bc;
        if (!reset) begin
            ms = M_IDLE; mr = 0; mp = 0; mt = 0; mw = 0;
        end else if (ms == M_IDLE || ms == M_DONE) begin
            if (s) begin ms = M_SHOW; mr = 0; mp = 0; mt = 0; mw = 0; end
        end else if (ms == M_SHOW) begin
            if (sd) begin ms = M_WAIT; mp = 0; mt = 0; end
        end else if (bv) begin
            mt = 0;
            if (bc != mem[mp]) ms = M_DONE;
            else if (mp < mr) mp++;
            else begin
                mr++;
                mw = (mr == MAXR);
                ms = mw ? M_DONE : M_SHOW;
            end
        end else if (t) begin
            mt++;
            if (mt == TOUT) ms = M_DONE;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.tick = 1'b0;
        bus.show_done = 1'b0;
        bus.btn_valid = 1'b0;
        bus.btn_code = 2'd0;
        check_outputs();
    endtask
    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 2'd0);
    endtask
    task automatic press(input colour_t c);
        step(0, 0, 0, 1, c);
        idle(int'($urandom_range(1, 2)));
    endtask
    task automatic tick_gap();
        step(0, 1, 0, 0, 2'd0);
        idle(int'($urandom_range(0, 2)));
    endtask
    task automatic play_round();
        int r;
        r = mr;
        step(0, 0, 1, 0, 2'd0);
        idle(1);
        for (int i = 0; i <= r; i++) press(mem[i]);
    endtask
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = colour_t'($urandom_range(0, 3));
        phase = "reset";
        idle(2);
        chk("reset_round", 8'(bus.round), 8'd0);
        chk("reset_playing", 8'(bus.playing), 8'd0);
        reset = 1'b1;
        idle(1);
        phase = "game1";
        step(1, 0, 0, 0, 2'd0);
        idle(2);
        repeat (3) play_round();
        chk("round_three", 8'(bus.round), 8'd3);
        step(0, 0, 1, 0, 2'd0);
        idle(1);
        press(mem[0]);
        phase = "mid_reset";
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("mid_reset_round", 8'(bus.round), 8'd0);
        chk("mid_reset_playing", 8'(bus.playing), 8'd0);
        chk("mid_reset_end_game", 8'(bus.end_game), 8'd0);
        idle(1);
        phase = "mismatch";
        step(1, 0, 0, 0, 2'd0);
        idle(1);
        play_round();
        chk("round_one", 8'(bus.round), 8'd1);
        chk("show_again", 8'(bus.show_req), 8'd1);
        play_round();
        step(0, 0, 1, 0, 2'd0);
        idle(1);
        press(mem[0]);
        step(0, 0, 0, 1, mem[1] ^ 2'd1);
        chk("mismatch_end", 8'(bus.end_game), 8'd1);
        chk("mismatch_win", 8'(bus.win), 8'd0);
        chk("mismatch_round", 8'(bus.round), 8'd2);
        idle(1);
        press(mem[1]);
        step(0, 1, 1, 0, 2'd0);
        idle(1);
        phase = "restart";
        step(1, 0, 0, 0, 2'd0);
        chk("restart_round", 8'(bus.round), 8'd0);
        chk("restart_show", 8'(bus.show_req), 8'd1);
        step(1, 0, 0, 0, 2'd0);
        step(0, 0, 1, 0, 2'd0);
        step(1, 0, 0, 0, 2'd0);
        chk("start_in_wait", 8'(bus.playing), 8'd1);
        phase = "timeout";
        tick_gap();
        tick_gap();
        chk("before_timeout", 8'(bus.end_game), 8'd0);
        step(0, 1, 0, 0, 2'd0);
        chk("timeout_end", 8'(bus.end_game), 8'd1);
        chk("timeout_win", 8'(bus.win), 8'd0);
        phase = "coincident";
        step(1, 0, 0, 0, 2'd0);
        idle(1);
        play_round();
        step(0, 0, 1, 0, 2'd0);
        tick_gap();
        tick_gap();
        step(0, 1, 0, 1, mem[0]);
        idle(1);
        tick_gap();
        step(0, 1, 0, 0, 2'd0);
        chk("timer_cleared", 8'(bus.playing), 8'd1);
        press(mem[1]);
        chk("round_two", 8'(bus.round), 8'd2);
        phase = "win";
        step(0, 0, 1, 1, mem[0] ^ 2'd2);
        idle(1);
        for (int i = 0; i <= 2; i++) press(mem[i]);
        play_round();
        chk("win_flag", 8'(bus.win), 8'd1);
        chk("win_round", 8'(bus.round), 8'(MAXR));
        phase = "random";
        for (int n = 0; n < 600; n++) begin
            bit s, t, sd, bv;
            colour_t c;
            reset = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 24) == 0);
            t = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 4) == 0);
            bv = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 9) < 8) ? mem[mp] : colour_t'($urandom_range(0, 3));
            step(s, t, sd, bv, c);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_checker.md
# round_checker

Game-progress controller of the sequence memory game. It requests display of the current sequence, compares each player button press against the stored colour sequence, and counts fully matched rounds. It ends the game on a mismatch, an inactivity timeout or reaching the maximum round. Its `round` output feeds the scoring logic directly; the sequence memory and the display module sit beside it.

## Interface
Parameters:
- `P_ROUND`, 4, width of `round` and `seq_addr`
- `P_MAX_ROUND`, 15, round count that wins the game; must be 1..2^P_ROUND−1
- `P_TIMEOUT`, 5, number of `tick` strobes without a press that end the game; must be ≥1

Ports:
- `clock`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a new game
- `tick`  in  1  one-cycle timebase strobe, nominally 1 Hz
- `show_done`  in  1  one-cycle pulse from display: sequence playback finished
- `btn_valid`  in  1  one-cycle pulse per debounced button press
- `btn_code`  in  2  colour index of the press; valid with `btn_valid`
- `seq_data`  in  2  colour index stored at `seq_addr`; combinational read, valid in the same cycle
- `seq_addr`  out  P_ROUND  sequence position under comparison
- `show_req`  out  1  level; display must play elements 0..round
- `round`  out  P_ROUND  number of sequences fully matched
- `playing`  out  1  high in SHOW and WAIT
- `end_game`  out  1  high in DONE
- `win`  out  1  valid while `end_game`=1; 1 = reached P_MAX_ROUND

## Operation
States: IDLE, SHOW, WAIT, DONE.
- IDLE: all outputs 0. `start` → SHOW; clear `round`, `pos` and `timer`.
- SHOW: `show_req`=1. `show_done` → WAIT; `pos`←0, `timer`←0. Presses are ignored.
- WAIT: `seq_addr`=`pos`. On `btn_valid`:
  - Match (`btn_code`==`seq_data`) with `pos`==`round` (last element of this round):
    - `round`←`round`+1.
    - If the new value equals P_MAX_ROUND → DONE with `win`←1.
    - Otherwise → SHOW.
  - Match with `pos`<`round`: `pos`←`pos`+1, `timer`←0.
  - Mismatch: → DONE with `win`←0. `round` is unchanged.
- WAIT timeout: on `tick` with no `btn_valid`, `timer`←`timer`+1. When `timer` reaches P_TIMEOUT → DONE with `win`←0.
- DONE: `end_game`=1. `round`, `win` and `seq_addr` are held for scoring. `start` → SHOW with `round`, `pos`, `timer` and `win` cleared.
- Round r requires r+1 presses, at addresses 0..r. `round` never exceeds P_MAX_ROUND and does not wrap.
- Ignored inputs:
  - `start` in SHOW/WAIT.
  - `btn_valid` outside WAIT.
  - `show_done` outside SHOW.
  - `tick` outside WAIT.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; all outputs, `pos` and `timer` are 0. Reset takes priority over every input, including mid-game.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs except through `seq_data`→compare→next state.
- `start` at edge n: `show_req`=1 and `playing`=1 from cycle n+1.
- Press at edge n:
  - `round`, `pos` and state update at n+1.
  - `end_game` is visible at n+1.
  - `seq_addr` advances at n+1, so the next `seq_data` is ready before the next press (presses are ≥2 cycles apart).
- `btn_valid` and `tick` in the same cycle: the press is processed, `timer`←0, and the timeout is not evaluated.
- `show_done` and `btn_valid` in the same cycle in SHOW: the transition to WAIT occurs and the press is discarded.
- Timeout: DONE is entered on the edge of the P_TIMEOUT-th counted tick.

## Structure
- Shared package `game_pkg`:
  - state encoding: IDLE=0, SHOW=1, WAIT=2, DONE=3
  - colour codes (2-bit)
  - `P_ROUND` default
- Sub-module `timeout_counter`:
  - clear/tick inputs, P_TIMEOUT parameter, `expired` output
  - synchronous active-low reset shared with the parent

## Test plan
- Reset mid-WAIT with round=3 → next cycle: IDLE, `round`=0, `playing`=0, `end_game`=0.
- `start`; `show_done`; press `seq_data`[0] → `round`=1, state SHOW. `show_done`; press [0] then [1] → `round`=2.
- Round 2 (`round`=2), press wrong colour at pos 1 → `end_game`=1 next cycle, `win`=0, `round` held at 2, later presses ignored.
- P_MAX_ROUND=2: match rounds 0 and 1 correctly → `round`=2, `end_game`=1, `win`=1.
- P_TIMEOUT=3, in WAIT with no press: 3 ticks → DONE, `win`=0. Separate case: tick and press coincident on the 3rd tick → no timeout, `timer`=0.
- In DONE, pulse `start` → SHOW, `round`=0, `win`=0. A `start` pulsed during WAIT is ignored.
